picomips_controller: RTL and testbench

Sequencing controller for the picoMIPS core. It sits between the instruction decoder and the program counter/register file, and owns the only multi-cycle behaviour in the design. It stretches MULT/MULTI over a fixed number of cycles and stalls WLD0/WLD1 until the debounced handshake switch (sw[8]) reaches the required level. It then grants one register-write commit and one PC increment per instruction.

---
 rtl/picomips_ctrl_pkg.sv | 11 +
 rtl/handshake_debounce.sv | 47 ++++
 rtl/opcodes.sv | 17 +
 rtl/picomips_controller.sv | 139 +++++++++++++
 tb/tb_picomips_controller.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/picomips_ctrl_pkg.sv
// picoMIPS sequencing controller: shared types.
// State encoding for the controller FSM.
package picomips_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MULT_BUSY = 2'd1,
    WAIT_HS   = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/handshake_debounce.sv
// Two-flop synchroniser and counting debouncer
// for the bouncy handshake switch.
module handshake_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic stable_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sw_meta;
  logic          sw_sync;
  logic          sw_stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sw_meta <= raw_in;
      sw_sync <= sw_meta;
    end
  end

  // Flip only after a full run of disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_stable <= 1'b0;
      cnt       <= '0;
    end else if (sw_sync == sw_stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      sw_stable <= sw_sync;
      cnt       <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stable_out = sw_stable;

endmodule

// File: rtl/opcodes.sv
// Shared picoMIPS opcode encodings.
// Included by any block that decodes instructions.
`ifndef PICOMIPS_OPCODES_SV
`define PICOMIPS_OPCODES_SV

`define OPCODE_SIZE 4

`define OP_NOP   4'd0
`define OP_ADD   4'd1
`define OP_ADDI  4'd2
`define OP_SUBI  4'd3
`define OP_MULT  4'd4
`define OP_MULTI 4'd5
`define OP_WLD0  4'd6
`define OP_WLD1  4'd7

`endif

// File: rtl/picomips_controller.sv
// picoMIPS sequencing controller: stretches multiplies,
// stalls switch loads, grants one commit/PC step per instruction.
`include "opcodes.sv"

module picomips_controller
  import picomips_ctrl_pkg::*;
#(
  parameter int OPCODE_SIZE     = `OPCODE_SIZE,
  parameter int MULT_CYCLES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic                   handshake_switch,
  output logic                   pc_inc,
  output logic                   commit,
  output logic                   wait_hs,
  output logic                   busy
);

  localparam int MW = $clog2(MULT_CYCLES) + 1;
  localparam bit MULT_ONE = (MULT_CYCLES == 1);
  localparam logic [MW-1:0] MCNT_INIT =
    MW'((MULT_CYCLES > 1) ? (MULT_CYCLES - 2) : 0);

  ctrl_state_t   state, state_d;
  logic [MW-1:0] mcnt, mcnt_d;
  logic          target, target_d;
  logic          sw_stable;
  logic          go, wr;

  logic op_alu, op_mul, op_wld0, op_wld1;
  logic op_wld, wld_level;

  handshake_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (handshake_switch),
    .stable_out(sw_stable)
  );

  assign op_alu = (opcode == OPCODE_SIZE'(`OP_ADD))
               || (opcode == OPCODE_SIZE'(`OP_ADDI))
               || (opcode == OPCODE_SIZE'(`OP_SUBI));
  assign op_mul = (opcode == OPCODE_SIZE'(`OP_MULT))
               || (opcode == OPCODE_SIZE'(`OP_MULTI));
  assign op_wld0 = (opcode == OPCODE_SIZE'(`OP_WLD0));
  assign op_wld1 = (opcode == OPCODE_SIZE'(`OP_WLD1));
  assign op_wld = op_wld0 | op_wld1;
  assign wld_level = op_wld1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      mcnt   <= '0;
      target <= 1'b0;
    end else begin
      state  <= state_d;
      mcnt   <= mcnt_d;
      target <= target_d;
    end
  end

  always_comb begin
    state_d  = state;
    mcnt_d   = mcnt;
    target_d = target;
    unique case (state)
      RUN: begin
        unique case (1'b1)
          op_mul: begin
            if (!MULT_ONE) begin
              state_d = MULT_BUSY;
              mcnt_d  = MCNT_INIT;
            end
          end
          op_wld: begin
            if (sw_stable != wld_level) begin
              state_d  = WAIT_HS;
              target_d = wld_level;
            end
          end
          default: ;
        endcase
      end
      MULT_BUSY: begin
        if (mcnt == '0) state_d = RUN;
        else            mcnt_d  = mcnt - 1'b1;
      end
      WAIT_HS: begin
        if (sw_stable == target) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOP and undefined opcodes still step the PC, without a write.
  always_comb begin
    go = 1'b0;
    wr = 1'b0;
    unique case (state)
      RUN: begin
        unique case (1'b1)
          op_alu: begin
            go = 1'b1;
            wr = 1'b1;
          end
          op_mul: begin
            go = MULT_ONE;
            wr = MULT_ONE;
          end
          op_wld: begin
            go = (sw_stable == wld_level);
            wr = (sw_stable == wld_level);
          end
          default: go = 1'b1;
        endcase
      end
      MULT_BUSY: begin
        go = (mcnt == '0);
        wr = (mcnt == '0);
      end
      WAIT_HS: begin
        go = (sw_stable == target);
        wr = (sw_stable == target);
      end
      default: ;
    endcase
  end

  assign pc_inc  = go & ~reset;
  assign commit  = wr & ~reset;
  assign wait_hs = (state == WAIT_HS) & ~reset;
  assign busy    = (state != RUN) & ~reset;

endmodule

// File: tb/tb_picomips_controller.sv
// Scoreboard bench for picomips_controller
// (MULT_CYCLES=3, DEBOUNCE_CYCLES=4).
module tb_picomips_controller;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] ADD   = 4'd1;
  localparam logic [3:0] ADDI  = 4'd2;
  localparam logic [3:0] SUBI  = 4'd3;
  localparam logic [3:0] MULT  = 4'd4;
  localparam logic [3:0] MULTI = 4'd5;
  localparam logic [3:0] WLD0  = 4'd6;
  localparam logic [3:0] WLD1  = 4'd7;
  localparam logic [3:0] UNDEF = 4'd11;

  typedef struct {
    bit c;
    int at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw;
  logic [3:0] opcode;
  logic       pc_inc, commit, wait_hs, busy;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  picomips_controller #(
    .OPCODE_SIZE    (4),
    .MULT_CYCLES    (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk             (clk),
    .reset           (rst),
    .opcode          (opcode),
    .handshake_switch(sw),
    .pc_inc          (pc_inc),
    .commit          (commit),
    .wait_hs         (wait_hs),
    .busy            (busy)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic chk_zero(input string name);
    check({name, "_pc_inc"}, int'(pc_inc), 0);
    check({name, "_commit"}, int'(commit), 0);
    check({name, "_wait_hs"}, int'(wait_hs), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  // One cycle: drive, queue the expected pulse, check state flags.
  task automatic step(input logic [3:0] op, input bit sw_v,
                      input bit ep, input bit ec,
                      input bit eb, input bit ew);
    opcode = op;
    sw = sw_v;
    if (ep) exp_q.push_back('{c: ec, at: cyc});
    #3;
    check("busy", int'(busy), int'(eb));
    check("wait_hs", int'(wait_hs), int'(ew));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && commit && !pc_inc) begin
      total++;
      bad++;
      $display("FAIL lone_commit: commit=1 pc_inc=0 (cycle %0d)", cyc);
    end
    if (!rst && pc_inc) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spare_pulse: pc_inc=1 none expected (cycle %0d)",
                 cyc);
      end else begin
        e_mon = exp_q.pop_front();
        check("pulse_cycle", cyc, e_mon.at);
        check("pulse_commit", int'(commit), int'(e_mon.c));
      end
    end
  end

  initial begin
    rst = 1'b1;
    sw = 1'b0;
    opcode = NOP;
    #2;
    chk_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_held");
    rst = 1'b0;

    // single-cycle instructions
    step(ADD, 0, 1, 1, 0, 0);
    step(ADDI, 0, 1, 1, 0, 0);
    step(SUBI, 0, 1, 1, 0, 0);
    step(NOP, 0, 1, 0, 0, 0);
    step(UNDEF, 0, 1, 0, 0, 0);

    // three-cycle multiplies
    step(MULT, 0, 0, 0, 0, 0);
    step(MULT, 0, 0, 0, 1, 0);
    step(MULT, 0, 1, 1, 1, 0);
    step(MULTI, 0, 0, 0, 0, 0);
    step(MULTI, 0, 0, 0, 1, 0);
    step(MULTI, 0, 1, 1, 1, 0);
    step(ADD, 0, 1, 1, 0, 0);

    // WLD1, clean rising edge sampled one edge after it is driven
    step(WLD1, 0, 0, 0, 0, 0);
    step(WLD1, 0, 0, 0, 1, 1);
    repeat (6) step(WLD1, 1, 0, 0, 1, 1);
    step(WLD1, 1, 1, 1, 1, 1);
    step(NOP, 1, 1, 0, 0, 0);

    // WLD1 with the switch already high
    step(WLD1, 1, 1, 1, 0, 0);

    // WLD0 with two 3-cycle glitches, then a solid low
    step(WLD0, 1, 0, 0, 0, 0);
    repeat (2) begin
      repeat (3) step(WLD0, 0, 0, 0, 1, 1);
      repeat (6) step(WLD0, 1, 0, 0, 1, 1);
    end
    repeat (6) step(WLD0, 0, 0, 0, 1, 1);
    step(WLD0, 0, 1, 1, 1, 1);
    step(NOP, 0, 1, 0, 0, 0);
    step(WLD0, 0, 1, 1, 0, 0);

    // reset while stalled in WAIT_HS
    step(WLD1, 0, 0, 0, 0, 0);
    step(WLD1, 0, 0, 0, 1, 1);
    rst = 1'b1;
    #1;
    chk_zero("reset_mid");
    @(posedge clk);
    #1;
    chk_zero("reset_mid_held");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(NOP, 0, 1, 0, 0, 0);
    step(ADD, 0, 1, 1, 0, 0);

    rst = 1'b1;
    #2;
    check("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
